// File: rtl/ws2812_pattern_gen_if.sv
// Write-side bus between the pattern generator and the ws2812 driver.
// The generator is the master; the driver answers with ready.
interface ws2812_pattern_gen_if #(
   parameter int NUM_LEDS = 4
);
   logic                ready;
   logic [NUM_LEDS-1:0] led_mask;
   logic [23:0]         rgb_colour;
   logic                write;

   modport master (input ready, output led_mask, rgb_colour, write);
   modport slave  (output ready, input led_mask, rgb_colour, write);
endinterface

// File: rtl/ws2812_pattern_gen.sv
// Per-frame colour-effect engine: walks every LED and issues one GRB write each.
// Define GAMMA_EN to apply a square-law gamma curve after brightness scaling.
module ws2812_pattern_gen #(
   parameter int NUM_LEDS        = 4,
   parameter int TICK_DIV        = 65536,
   parameter int HUE_STEP        = 1,
   parameter int LED_HUE_SPACING = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        enable,
   input  logic [1:0]                  mode,
   input  logic [7:0]                  brightness,
   ws2812_pattern_gen_if.master        led_if,
   output logic                        busy,
   output logic                        overrun
);
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
   localparam logic [7:0] HUE_INC = 8'(HUE_STEP);
   localparam logic [1:0] MODE_RAINBOW = 2'd1;
   localparam logic [1:0] MODE_CHASE   = 2'd2;
   localparam logic [1:0] MODE_OFF     = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_WRITE} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    tick_cnt;
   logic                tick;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    chase_pos;
   logic [7:0]          wheel;
   logic [1:0]          mode_l;
   logic [7:0]          bri_l;
   logic                start;
   logic                write_c;
   logic [7:0]          hue_p0;
   logic [23:0]         rgb_p0;
   logic [NUM_LEDS-1:0] mask_r;
   logic [23:0]         rgb_r;

   function automatic logic [23:0] hue_to_grb(input logic [7:0] h);
      logic [7:0] d, up, dn;
      if (h < 8'd85)       d = h;
      else if (h < 8'd170) d = h - 8'd85;
      else                 d = h - 8'd170;
      up = 8'(d * 8'd3);
      dn = 8'd255 - up;
      if (h < 8'd85)       return {8'd0, dn, up};
      else if (h < 8'd170) return {up, 8'd0, dn};
      else                 return {dn, up, 8'd0};
   endfunction

   function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] p;
      p = {8'd0, c} * ({8'd0, b} + 16'd1);
      return 8'(p >> 8);
   endfunction

   function automatic logic [7:0] gamma_ch(input logic [7:0] c);
      logic [15:0] q;
      q = {8'd0, c} * {8'd0, c} + {8'd0, c};
      return 8'(q >> 8);
   endfunction

   function automatic logic [23:0] grade(input logic [23:0] grb, input logic [7:0] b);
      logic [7:0] g, r, bl;
      g  = scale_ch(grb[23:16], b);
      r  = scale_ch(grb[15:8], b);
      bl = scale_ch(grb[7:0], b);
`ifdef GAMMA_EN
      g  = gamma_ch(g);
      r  = gamma_ch(r);
      bl = gamma_ch(bl);
`endif
      return {g, r, bl};
   endfunction

   assign tick = (tick_cnt == CNT_LAST);

   // Colour stage p0: hue select, wheel lookup and grading, captured in COMPUTE
   always_comb begin
      hue_p0 = wheel;
      if (mode_l == MODE_RAINBOW)
         hue_p0 = wheel + 8'(32'(idx) * LED_HUE_SPACING);
      rgb_p0 = grade(hue_to_grb(hue_p0), bri_l);
      if (mode_l == MODE_OFF || (mode_l == MODE_CHASE && idx != chase_pos))
         rgb_p0 = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      write_c   = 1'b0;
      case (state)
         S_IDLE: begin
            if (tick && enable) begin
               start     = 1'b1;
               state_nxt = S_COMPUTE;
            end
         end
         S_COMPUTE: state_nxt = S_WRITE;
         S_WRITE: begin
            if (led_if.ready) begin
               write_c   = 1'b1;
               state_nxt = (idx == IDX_LAST) ? S_IDLE : S_COMPUTE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt  <= '0;
         overrun   <= 1'b0;
         idx       <= '0;
         chase_pos <= '0;
         wheel     <= 8'd0;
         mode_l    <= 2'd0;
         bri_l     <= 8'd0;
         mask_r    <= '0;
         rgb_r     <= 24'd0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
         // A tick on the final-write cycle still counts as busy and is dropped.
         if (tick && state != S_IDLE)
            overrun <= 1'b1;
         if (start) begin
            mode_l <= mode;
            bri_l  <= brightness;
            idx    <= '0;
         end
         if (state == S_COMPUTE) begin
            rgb_r  <= rgb_p0;
            mask_r <= NUM_LEDS'(1) << idx;
         end
         if (write_c) begin
            if (idx == IDX_LAST) begin
               wheel     <= wheel + HUE_INC;
               chase_pos <= (chase_pos == IDX_LAST) ? '0 : chase_pos + IDX_W'(1);
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end
      end
   end

   assign led_if.write      = write_c;
   assign led_if.led_mask   = mask_r;
   assign led_if.rgb_colour = rgb_r;
   assign busy              = (state != S_IDLE);
endmodule

// File: tb/tb_ws2812_pattern_gen.sv
// Scoreboard bench for ws2812_pattern_gen: expected writes are queued per frame
// and popped by a write monitor; a second instance covers a non-unit hue step.
module tb_ws2812_pattern_gen;
   localparam int NL = 4;
   localparam int TD = 16;
   localparam int SP = 64;

   typedef struct packed {
      logic [NL-1:0] mask;
      logic [23:0]   rgb;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable, en3;
   logic [1:0] mode;
   logic [7:0] brightness;
   logic       busy, overrun, busy3, overrun3;

   int   vectors = 0;
   int   miscompares = 0;
   int   wheel_m = 0;
   int   chase_m = 0;
   exp_t q[$];
   exp_t mon_e;

   ws2812_pattern_gen_if #(.NUM_LEDS(NL)) lif ();
   ws2812_pattern_gen_if #(.NUM_LEDS(NL)) lif3 ();

   always #5 clk = ~clk;

   ws2812_pattern_gen #(.NUM_LEDS(NL), .TICK_DIV(TD), .HUE_STEP(1), .LED_HUE_SPACING(SP)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .brightness(brightness),
      .led_if(lif), .busy(busy), .overrun(overrun));

   ws2812_pattern_gen #(.NUM_LEDS(NL), .TICK_DIV(TD), .HUE_STEP(3), .LED_HUE_SPACING(16)) dut3 (
      .clk(clk), .reset_n(reset_n), .enable(en3), .mode(mode), .brightness(brightness),
      .led_if(lif3), .busy(busy3), .overrun(overrun3));

   function automatic logic [23:0] exp_colour(int m, int w, int i, int ch, int b);
      int h, r, g, bl;
      if (m == 3 || (m == 2 && i != ch)) return 24'h000000;
      h = (m == 1) ? (w + i * SP) % 256 : w;
      if (h < 85)       begin r = 255 - 3 * h; g = 0; bl = 3 * h; end
      else if (h < 170) begin r = 0; g = 3 * (h - 85); bl = 255 - 3 * (h - 85); end
      else              begin r = 3 * (h - 170); g = 255 - 3 * (h - 170); bl = 0; end
      r  = r * (b + 1) / 256;
      g  = g * (b + 1) / 256;
      bl = bl * (b + 1) / 256;
`ifdef GAMMA_EN
      r  = (r * r + r) / 256;
      g  = (g * g + g) / 256;
      bl = (bl * bl + bl) / 256;
`endif
      return {g[7:0], r[7:0], bl[7:0]};
   endfunction

   always @(negedge clk) begin
      if (reset_n === 1'b1 && lif.write === 1'b1) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write mask=%b rgb=%h required no write", lif.led_mask, lif.rgb_colour);
         end else begin
            mon_e = q.pop_front();
            if (lif.led_mask !== mon_e.mask || lif.rgb_colour !== mon_e.rgb) begin
               miscompares++;
               $display("FAIL write mask=%b rgb=%h required mask=%b rgb=%h",
                        lif.led_mask, lif.rgb_colour, mon_e.mask, mon_e.rgb);
            end
         end
      end
   end

   task automatic push_lit(input logic [23:0] c0, c1, c2, c3);
      logic [23:0] c[4];
      exp_t e;
      c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
      for (int i = 0; i < NL; i++) begin
         e.mask = NL'(1) << i;
         e.rgb  = c[i];
         q.push_back(e);
      end
   endtask

   task automatic push_model(input int m, input int b);
      exp_t e;
      for (int i = 0; i < NL; i++) begin
         e.mask = NL'(1) << i;
         e.rgb  = exp_colour(m, wheel_m, i, chase_m, b);
         q.push_back(e);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      enable  = 1'b0;
      en3     = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      wheel_m = 0;
      chase_m = 0;
      q.delete();
   endtask

   // Runs exactly one frame; mode/brightness switch to m2/b2 once the frame is underway.
   task automatic run_frame(input int m, input int b, input bit push, input int m2, input int b2);
      int n;
      if (push) push_model(m, b);
      mode = 2'(m); brightness = 8'(b); enable = 1'b1;
      n = 0;
      while (busy !== 1'b1 && n < 3 * TD) begin @(posedge clk); #1; n++; end
      enable = 1'b0;
      if (busy !== 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL frame_start busy=%b required 1 within %0d cycles", busy, 3 * TD);
         q.delete();
         return;
      end
      mode = 2'(m2); brightness = 8'(b2);
      n = 0;
      while (busy === 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL frame_end busy=%b required 0", busy);
      end
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL frame_writes missing=%0d required 0", q.size());
      end
      q.delete();
      wheel_m = (wheel_m + 1) % 256;
      chase_m = (chase_m == NL - 1) ? 0 : chase_m + 1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (lif.write !== 1'b0) begin miscompares++; $display("FAIL reset_write got=%b required 0", lif.write); end
      vectors++; if (lif.led_mask !== '0) begin miscompares++; $display("FAIL reset_mask got=%b required 0", lif.led_mask); end
      vectors++; if (lif.rgb_colour !== 24'h0) begin miscompares++; $display("FAIL reset_rgb got=%h required 0", lif.rgb_colour); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b required 0", busy); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got=%b required 0", overrun); end
   endtask

   task automatic test_solid();
      do_reset();
      push_lit(24'h00FF00, 24'h00FF00, 24'h00FF00, 24'h00FF00);
      run_frame(0, 255, 1'b0, 0, 255);
      run_frame(0, 255, 1'b1, 0, 255);
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL solid_overrun got=%b required 0", overrun); end
   endtask

   task automatic test_rainbow();
      do_reset();
`ifdef GAMMA_EN
      run_frame(1, 255, 1'b1, 1, 255);
`else
      push_lit(24'h00FF00, 24'h003FC0, 24'h81007E, 24'hBD4200);
      run_frame(1, 255, 1'b0, 1, 255);
`endif
   endtask

   task automatic test_brightness();
      do_reset();
`ifdef GAMMA_EN
      push_lit(24'h003F00, 24'h003F00, 24'h003F00, 24'h003F00);
`else
      push_lit(24'h007F00, 24'h007F00, 24'h007F00, 24'h007F00);
`endif
      run_frame(0, 127, 1'b0, 3, 0);
      run_frame(0, 0, 1'b1, 0, 0);
   endtask

   task automatic test_chase();
      do_reset();
      for (int f = 0; f < 5; f++) run_frame(2, 255, 1'b1, 2, 255);
   endtask

   task automatic test_off();
      push_lit(24'h0, 24'h0, 24'h0, 24'h0);
      run_frame(3, 255, 1'b0, 3, 255);
   endtask

   task automatic test_stall();
      int n;
      bit bad;
      do_reset();
      push_model(0, 255);
      mode = 2'd0; brightness = 8'd255; enable = 1'b1;
      n = 0;
      while (!(lif.write === 1'b1 && lif.led_mask === 4'b0001) && n < 3 * TD) begin @(posedge clk); #1; n++; end
      enable = 1'b0;
      vectors++;
      if (lif.write !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_first_write write=%b required 1", lif.write);
      end
      @(posedge clk); #1;
      lif.ready = 1'b0;
      bad = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (lif.write !== 1'b0 || lif.led_mask !== 4'b0010 || busy !== 1'b1) bad = 1'b1;
      end
      vectors++; if (bad) begin miscompares++; $display("FAIL stall_hold unstable=1 required 0"); end
      vectors++; if (lif.led_mask !== 4'b0010) begin miscompares++; $display("FAIL stall_mask got=%b required 0010", lif.led_mask); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy got=%b required 1", busy); end
      vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL stall_overrun got=%b required 1", overrun); end
      lif.ready = 1'b1;
      n = 0;
      while (busy === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      vectors++; if (q.size() != 0 || busy !== 1'b0) begin
         miscompares++; $display("FAIL stall_finish missing=%0d busy=%b required 0 0", q.size(), busy);
      end
      q.delete();
      vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky got=%b required 1", overrun); end
   endtask

   task automatic test_hue_step();
      int n;
      logic [23:0] exp_rgb;
      logic [NL-1:0] exp_mask;
      do_reset();
      mode = 2'd0; brightness = 8'd255;
      en3 = 1'b1;
      for (int f = 0; f < 87; f++) begin
         for (int l = 0; l < NL; l++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (lif3.write !== 1'b1 && n < 40);
            if (lif3.write !== 1'b1) begin
               vectors++; miscompares++;
               $display("FAIL hue_step_timeout frame=%0d led=%0d", f, l);
            end else if (f >= 84) begin
               exp_rgb  = exp_colour(0, (3 * f) % 256, l, 0, 255);
               exp_mask = NL'(1) << l;
               vectors++;
               if (lif3.rgb_colour !== exp_rgb || lif3.led_mask !== exp_mask) begin
                  miscompares++;
                  $display("FAIL hue_step frame=%0d mask=%b rgb=%h required mask=%b rgb=%h",
                           f, lif3.led_mask, lif3.rgb_colour, exp_mask, exp_rgb);
               end
            end
         end
      end
      en3 = 1'b0;
      vectors++;
      if (overrun3 !== 1'b0) begin miscompares++; $display("FAIL hue_step_overrun got=%b required 0", overrun3); end
   endtask

   task automatic test_reset_midframe();
      int n;
      do_reset();
      push_model(0, 255);
      mode = 2'd0; brightness = 8'd255; enable = 1'b1;
      n = 0;
      while (lif.led_mask !== 4'b0010 && n < 3 * TD) begin @(posedge clk); #1; n++; end
      enable = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got=%b required 0", busy); end
      vectors++; if (lif.led_mask !== '0 || lif.rgb_colour !== 24'h0 || lif.write !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_outputs mask=%b rgb=%h write=%b required 0 0 0", lif.led_mask, lif.rgb_colour, lif.write);
      end
      q.delete();
      do_reset();
      push_lit(24'h00FF00, 24'h00FF00, 24'h00FF00, 24'h00FF00);
      run_frame(0, 255, 1'b0, 0, 255);
   endtask

   initial begin
      reset_n = 1'b0;
      enable = 1'b0;
      en3 = 1'b0;
      mode = 2'd0;
      brightness = 8'd255;
      lif.ready = 1'b1;
      lif3.ready = 1'b1;
      test_reset();
      test_solid();
      test_rainbow();
      test_brightness();
      test_chase();
      test_off();
      test_stall();
      test_hue_step();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ws2812_pattern_gen.md
Name: ws2812_pattern_gen

Overview:
- Parametrised colour-effect engine that feeds the ws2812 driver. Drives its led_mask / rgb_colour / write inputs.
- On each frame tick it walks every LED index and computes a GRB colour from a shared hue wheel plus the selected effect mode. It issues one single-cycle write per LED under a ready handshake.
- Generalises the fixed single-pattern top-level generator: LED count, frame rate, hue step and per-LED hue spacing are parameters; mode and brightness are set at runtime.

Parameters:
- NUM_LEDS, 4, number of LEDs on the chain; led_mask width. Must be >= 1.
- TICK_DIV, 65536, clk cycles per frame tick. Must be >= 2.
- HUE_STEP, 1, wheel increment per frame, mod 256.
- LED_HUE_SPACING, 16, hue offset between adjacent LEDs in RAINBOW mode, mod 256.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  allows new frames to start.
- mode  in  2  0=SOLID, 1=RAINBOW, 2=CHASE, 3=OFF.
- brightness  in  8  global scale; 255 = unity.
- ready  in  1  driver can accept a write this cycle.
- led_mask  out  NUM_LEDS  one-hot target LED of the current write.
- rgb_colour  out  24  {green, red, blue}.
- write  out  1  single-cycle write strobe.
- busy  out  1  frame in progress.
- overrun  out  1  sticky; a tick arrived while busy.

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0; wheel=0, chase_pos=0, tick counter=0, LED index=0; FSM enters IDLE. Reset asserted mid-frame aborts the frame immediately.
- Tick counter: counts 0..TICK_DIV-1 then wraps. tick is a 1-cycle pulse when count==TICK_DIV-1. The counter runs regardless of enable.
- FSM states: IDLE, COMPUTE, WRITE.
  - IDLE: on tick && enable, latch mode and brightness, set idx=0, set busy=1, go to COMPUTE.
  - COMPUTE: one cycle. Register rgb_colour for idx. Set led_mask = 1<<idx. Go to WRITE.
  - WRITE: wait while ready=0 with write=0 and outputs held stable. On the first cycle with ready=1, write=1 for exactly that cycle. Then:
    - if idx==NUM_LEDS-1: wheel += HUE_STEP (8-bit wrap); chase_pos = (chase_pos==NUM_LEDS-1) ? 0 : chase_pos+1; busy=0; go to IDLE.
    - otherwise: idx++ and go to COMPUTE.
- Latency: first write no earlier than 2 cycles after the tick. Each further LED takes at least 2 cycles.
- led_mask and rgb_colour keep their last values in IDLE. write is never high in IDLE or COMPUTE.
- Hue per LED:
  - SOLID: h = wheel.
  - RAINBOW: h = wheel + idx*LED_HUE_SPACING, mod 256.
  - CHASE: h = wheel if idx==chase_pos, otherwise the colour is forced to 0.
  - OFF: colour forced to 0, but writes are still issued for every LED.
- Wheel (8-bit results):
  - h < 85: R = 255-3h, G = 0, B = 3h.
  - h < 170: R = 0, G = 3(h-85), B = 255-3(h-85).
  - else: R = 3(h-170), G = 255-3(h-170), B = 0.
- Brightness: each channel c' = (c*(brightness+1))>>8, computed with a 16-bit product. brightness=255 gives c'=c; brightness=0 gives c' = c>>8 = 0.
- Mode and brightness changes mid-frame take effect at the next frame only.
- enable deasserted mid-frame: the current frame completes; no new frame starts.
- A tick while busy is dropped and sets overrun=1. overrun clears only on reset.
- A tick in the same cycle as the final write is treated as busy: it is dropped and sets overrun.

Optional Feature:
- GAMMA_EN defined: after brightness scaling, each channel c'' = (c'*c' + c')>>8. This maps 0->0, 255->255 and 16->1. It is applied inside COMPUTE with no added latency.
- GAMMA_EN not defined: channels are output linearly after brightness scaling.
- The FSM, handshake and overrun behaviour are identical in both builds.

Test Plan:
- NUM_LEDS=4, TICK_DIV=16, SOLID, brightness=255, ready=1 after reset. Expect 4 writes with masks 0001, 0010, 0100, 1000, each rgb_colour=24'h00FF00. Expect wheel=1 after the frame.
- RAINBOW, LED_HUE_SPACING=64, wheel=0. Expect rgb 24'h00FF00, 24'h003FC0, 24'h81007E, 24'hBD4200 for LEDs 0..3.
- SOLID, wheel=0, brightness=127. Expect rgb=24'h007F00. With GAMMA_EN defined, expect 24'h003F00.
- CHASE over 5 frames. Frame n has the only non-zero colour on LED n mod 4; the other three writes are 24'h000000.
- Hold ready=0 for 40 cycles during LED 1. Expect write held low, led_mask=0010 stable, busy=1, overrun=1 after the next tick. On ready=1, the frame completes normally.
- HUE_STEP=3 with wheel=255. After one frame, wheel=2. Pulse reset_n low mid-frame: outputs return to 0 immediately and busy=0.
